// File: rtl/icache_two_way_read_path.sv
// Two-way set-associative instruction cache read path: tag/valid/data banks,
// hit encoding and word selection. Results appear two cycles after issue.
module icache_two_way_read_path #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int WORD_PER_BLOCK = 16,
   parameter int MEMORY_DEPTH   = 512,
   localparam int BLOCK_WIDTH   = 16 * DATA_WIDTH,
   localparam int LINE_SELECT   = $clog2(MEMORY_DEPTH),
   localparam int TAG_WIDTH     = ADDRESS_WIDTH - LINE_SELECT - 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDRESS_WIDTH-1:0] read_address_i,
   input  logic                     read_enable_i,
   input  logic                     write_enable_i,
   input  logic                     write_bank_i,
   input  logic [LINE_SELECT-1:0]   write_line_i,
   input  logic [TAG_WIDTH-1:0]     write_tag_i,
   input  logic [BLOCK_WIDTH-1:0]   write_block_i,
   output logic                     out_valid_o,
   output logic                     hit_o,
   output logic                     hit_bank_o,
   output logic [DATA_WIDTH-1:0]    data_out_o
);

   logic [LINE_SELECT-1:0] rd_line;
   logic [TAG_WIDTH-1:0]   rd_tag;
   logic [3:0]             rd_word;
   logic                   unused_byte;

   assign rd_word     = read_address_i[5:2];
   assign rd_line     = read_address_i[5+LINE_SELECT:6];
   assign rd_tag      = read_address_i[ADDRESS_WIDTH-1:6+LINE_SELECT];
   assign unused_byte = ^read_address_i[1:0];

   logic [TAG_WIDTH-1:0]   tag_mem  [2][MEMORY_DEPTH];
   logic [BLOCK_WIDTH-1:0] data_mem [2][MEMORY_DEPTH];
   logic [MEMORY_DEPTH-1:0] valid_q [2];

   logic [TAG_WIDTH-1:0]   tag_rd_q   [2];
   logic                   vld_rd_q   [2];
   logic [BLOCK_WIDTH-1:0] data_rd1_q [2];
   logic [BLOCK_WIDTH-1:0] data_rd2_q [2];
   logic                   hit_q      [2];
   logic [TAG_WIDTH-1:0]   tag2_q;
   logic [3:0]             word2_q;
   logic [3:0]             word3_q;
   logic                   v2_q;
   logic                   v3_q;

   // Array contents are intentionally left unreset; only valid bits gate hits.
   always_ff @(posedge clk) begin
      if (write_enable_i) begin
         tag_mem[write_bank_i][write_line_i]  <= write_tag_i;
         data_mem[write_bank_i][write_line_i] <= write_block_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            valid_q[b]    <= '0;
            tag_rd_q[b]   <= '0;
            vld_rd_q[b]   <= 1'b0;
            data_rd1_q[b] <= '0;
            data_rd2_q[b] <= '0;
            hit_q[b]      <= 1'b0;
         end
         tag2_q  <= '0;
         word2_q <= '0;
         word3_q <= '0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
      end else begin
         if (write_enable_i) begin
            valid_q[write_bank_i][write_line_i] <= 1'b1;
         end
         // Reads sample pre-write contents, giving read-first collisions.
         if (read_enable_i) begin
            for (int b = 0; b < 2; b++) begin
               tag_rd_q[b]   <= tag_mem[b][rd_line];
               vld_rd_q[b]   <= valid_q[b][rd_line];
               data_rd1_q[b] <= data_mem[b][rd_line];
            end
            tag2_q  <= rd_tag;
            word2_q <= rd_word;
         end
         if (v2_q) begin
            for (int b = 0; b < 2; b++) begin
               data_rd2_q[b] <= data_rd1_q[b];
            end
         end
         for (int b = 0; b < 2; b++) begin
            hit_q[b] <= v2_q & vld_rd_q[b] & (tag_rd_q[b] == tag2_q);
         end
         word3_q <= word2_q;
         v2_q    <= read_enable_i;
         v3_q    <= v2_q;
      end
   end

   logic                   hit_any;
   logic                   hit_bank;
   logic [BLOCK_WIDTH-1:0] block_sel;
   logic [DATA_WIDTH-1:0]  words [16];

   // Bank 0 wins when both banks hit.
   assign hit_any   = hit_q[0] | hit_q[1];
   assign hit_bank  = hit_q[1] & ~hit_q[0];
   assign block_sel = hit_bank ? data_rd2_q[1] : data_rd2_q[0];

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         words[i] = block_sel[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign out_valid_o = v3_q;
   assign hit_o       = hit_any;
   assign hit_bank_o  = hit_bank;
   assign data_out_o  = (v3_q & hit_any) ? words[word3_q] : '0;

endmodule

// File: tb/tb_icache_two_way_read_path.sv
// Directed bench for the two-way icache read path with hand-computed expectations.
module tb_icache_two_way_read_path;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LS = 9;
   localparam int TW = AW - LS - 6;
   localparam int BW = 16 * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] read_address;
   logic          read_enable;
   logic          write_enable;
   logic          write_bank;
   logic [LS-1:0] write_line;
   logic [TW-1:0] write_tag;
   logic [BW-1:0] write_block;
   logic          out_valid;
   logic          hit;
   logic          hit_bank;
   logic [DW-1:0] data_out;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   icache_two_way_read_path dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .read_address_i (read_address),
      .read_enable_i  (read_enable),
      .write_enable_i (write_enable),
      .write_bank_i   (write_bank),
      .write_line_i   (write_line),
      .write_tag_i    (write_tag),
      .write_block_i  (write_block),
      .out_valid_o    (out_valid),
      .hit_o          (hit),
      .hit_bank_o     (hit_bank),
      .data_out_o     (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic h,
                            input logic b, input logic [31:0] d);
      check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      check({tag, ".hit"},   {31'd0, hit},       {31'd0, h});
      check({tag, ".bank"},  {31'd0, hit_bank},  {31'd0, b});
      check({tag, ".data"},  data_out,           d);
   endtask

   function automatic logic [BW-1:0] make_block(input logic [31:0] base);
      logic [BW-1:0] blk;
      for (int i = 0; i < 16; i++) blk[i*32 +: 32] = base + i;
      return blk;
   endfunction

   task automatic write_line_t(input logic bank, input logic [LS-1:0] line,
                               input logic [TW-1:0] tag, input logic [31:0] base);
      write_enable = 1'b1;
      write_bank   = bank;
      write_line   = line;
      write_tag    = tag;
      write_block  = make_block(base);
      @(posedge clk); #1;
      write_enable = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [31:0] addr, input logic h,
                         input logic b, input logic [31:0] d);
      read_address = addr;
      read_enable  = 1'b1;
      @(posedge clk); #1;
      read_enable  = 1'b0;
      @(posedge clk); #1;
      check_out(tag, 1'b1, h, b, d);
   endtask

   initial begin
      rst_n = 1'b0;
      read_address = '0;
      read_enable = 1'b0;
      write_enable = 1'b0;
      write_bank = 1'b0;
      write_line = '0;
      write_tag = '0;
      write_block = '0;
      repeat (2) @(posedge clk);
      #1;
      check_out("in_reset", 1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;

      lookup("reset_read", 32'h0000_1234, 1'b0, 1'b0, 32'h0);

      // Bank 0 hit on every word, issued back-to-back
      write_line_t(1'b0, 9'd3, 17'h00001, 32'hA000_0000);
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) begin
            read_address = 32'h0000_80C0 + 4 * i;
            read_enable  = 1'b1;
         end else begin
            read_enable  = 1'b0;
         end
         @(posedge clk); #1;
         if (i >= 1) check_out($sformatf("b0_word%0d", i - 1), 1'b1, 1'b1, 1'b0,
                               32'hA000_0000 + (i - 1));
      end

      write_line_t(1'b1, 9'd3, 17'h00002, 32'hB000_0000);
      lookup("b1_hit", 32'h0001_00C8, 1'b1, 1'b1, 32'hB000_0002);
      write_line_t(1'b1, 9'd3, 17'h00001, 32'hB000_0000);
      lookup("both_hit_prio", 32'h0000_80C8, 1'b1, 1'b0, 32'hA000_0002);

      lookup("miss", 32'h0001_80C0, 1'b0, 1'b0, 32'h0);
      read_address = 32'h0000_80C8;
      read_enable  = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("no_issue.valid", {31'd0, out_valid}, 32'd0);

      // Same-line write and read in one cycle: old data, then new data
      write_enable = 1'b1;
      write_bank   = 1'b0;
      write_line   = 9'd3;
      write_tag    = 17'h00001;
      write_block  = make_block(32'hC000_0000);
      read_address = 32'h0000_80C8;
      read_enable  = 1'b1;
      @(posedge clk); #1;
      write_enable = 1'b0;
      @(posedge clk); #1;
      read_enable  = 1'b0;
      check_out("collide_old", 1'b1, 1'b1, 1'b0, 32'hA000_0002);
      @(posedge clk); #1;
      check_out("collide_new", 1'b1, 1'b1, 1'b0, 32'hC000_0002);

      // Reset mid-lookup with a hit currently on the outputs
      read_address = 32'h0000_80CC;
      read_enable  = 1'b1;
      @(posedge clk); #1;
      read_address = 32'h0000_80D0;
      @(posedge clk); #1;
      check_out("pre_reset", 1'b1, 1'b1, 1'b0, 32'hC000_0003);
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 1'b0, 1'b0, 1'b0, 32'h0);
      read_enable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      lookup("after_reset_miss", 32'h0000_80C8, 1'b0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/icache_two_way_read_path.md
# icache_two_way_read_path

Read path of the 2-way set-associative L1 instruction cache.
- Holds two tag banks and two data banks, built from DUAL_PORT_MEMORY-style arrays: tag banks are low-latency, data banks are high-latency.
- Per-line valid bits sit in flops.
- The 2-way hit encoder and a 16-to-1 word multiplexer turn a fetch address into one instruction word, with hit status, two cycles later.
- Sits between the PC/fetch stage and the L2 refill logic; refill drives the write port.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, fetch address width
- DATA_WIDTH, 32, instruction word width
- WORD_PER_BLOCK, 16, words per block; fixed at 16
- MEMORY_DEPTH, 512, lines per bank
- Derived values:
  - BLOCK_WIDTH = 16·DATA_WIDTH
  - LINE_SELECT = clog2(MEMORY_DEPTH)
  - TAG_WIDTH = ADDRESS_WIDTH − LINE_SELECT − 6

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- READ_ADDRESS  in  ADDRESS_WIDTH  fetch address; fields:
  - [1:0] byte (ignored)
  - [5:2] word
  - [5+LINE_SELECT:6] line
  - upper bits: tag
- READ_ENABLE  in  1  issue a lookup this cycle
- WRITE_ENABLE  in  1  refill write
- WRITE_BANK  in  1  bank written (0/1)
- WRITE_LINE  in  LINE_SELECT  line written
- WRITE_TAG  in  TAG_WIDTH  tag stored
- WRITE_BLOCK  in  BLOCK_WIDTH  block stored; word i is bits [32i+31:32i]
- OUT_VALID  out  1  result of a lookup present
- HIT  out  1  lookup hit in either bank
- HIT_BANK  out  1  bank that supplied data
- DATA_OUT  out  DATA_WIDTH  selected instruction word

## Operation
- **Memories:** each is a simple dual-port array with one write port and one read port.
  - A write updates tag, block and valid bit of line WRITE_LINE in bank WRITE_BANK; the other bank is untouched.
  - The valid bit is set to 1 by the write.
- **Read-enable hold:** with READ_ENABLE low, memory read registers hold their contents.
- **Hit detection:** for each bank, hit = valid[line] & (stored tag == registered address tag).
- **Encoder rules** (IN1 = hit bank 0, IN2 = hit bank 1; output = HIT_BANK):
  - only bank 1 hits → 1
  - only bank 0 hits → 0
  - both banks hit → 0 (bank 0 priority)
  - no hit → 0
- The 2-to-1 mux selects the block of HIT_BANK.
- **Word mux:** select = address word field from stage 3. Select 0 → bits [31:0], select 15 → bits [511:480].
- **Outputs:**
  - HIT = hit0 | hit1.
  - DATA_OUT = selected word when OUT_VALID & HIT, else 0.
  - HIT_BANK is 0 when not HIT.
- **Same-line read/write collision in the same cycle:** read-first. The lookup sees old tag, data and valid bit; a lookup issued on the following cycle sees the new contents.
- **Reset contents:** array contents are not reset. Valid bits are cleared, so every line misses until written.

## Timing
- Lookup issued at rising edge N (READ_ENABLE=1).
- **Tag banks (low latency):** registered read output at edge N. The address is registered into stage 2 at N.
- **Data banks (high latency):** two read registers, loaded at N and N+1.
- **Compare:** happens during cycle N→N+1. Per-bank hit bits are registered at edge N+1; the stage-3 address and stage valid are registered at edge N+1.
- **Outputs:** OUT_VALID, HIT, HIT_BANK and DATA_OUT are valid after edge N+1. They are combinational from stage-3 registers, so latency is 2 cycles.
- Throughput is 1 lookup/cycle with back-to-back issue; there are no bubbles.
- Stage valid shifts every cycle: READ_ENABLE=0 at edge N gives OUT_VALID=0 after N+1.
- **Reset (RST_N low, any time including mid-lookup):** immediately forces the following to 0 without waiting for a clock:
  - all stage valids, hit registers and memory read registers
  - all valid bits
  - OUT_VALID, HIT, HIT_BANK, DATA_OUT
- In-flight lookups are discarded. The first lookup may issue on the first rising edge after RST_N rises.

## Test plan
- **Reset then read:** reset, then read address 0x0000_1234 → OUT_VALID=1 two cycles later, HIT=0, DATA_OUT=0.
- **Bank 0 hit, every word:**
  - Stimulus: write bank 0, line 3, tag 0x00001, block with word i = 0xA000_0000+i; then read 0x0000_80C0 + 4·i for i = 0..15, back-to-back.
  - Response: after 2 cycles, consecutive outputs with HIT=1, HIT_BANK=0, DATA_OUT=0xA000_0000+i.
- **Bank 1 hit and priority:**
  - Write bank 1 at the same line with tag 0x00002 and words 0xB000_000i; read 0x0001_00C8 → HIT_BANK=1, DATA_OUT=0xB000_0002.
  - Rewrite bank 1 with tag 0x00001; read 0x0000_80C8 → HIT_BANK=0, DATA_OUT=0xA000_0002.
- **Miss:** read tag 0x00003 at line 3 → HIT=0, DATA_OUT=0. Then issue with READ_ENABLE=0 → OUT_VALID=0 two cycles later.
- **Collision:** write and read the same line in the same cycle → that lookup returns the old result; a read on the next cycle returns the new block.
- **Reset mid-lookup:** assert RST_N low between issue and output → outputs go to 0 immediately. A previously written line misses after reset.
